// File: rtl/riscv_run_controller_if.sv
// Bus between the run controller and whatever drives the core's result signals.
// master = controller side, slave = core/environment side.
interface riscv_run_controller_if #(
  parameter int TEST_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic [TEST_WIDTH-1:0] test_value;
  logic                  core_reset;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  fail;
  logic                  timeout;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [CNT_WIDTH-1:0]  change_count;
  logic [TEST_WIDTH-1:0] final_value;

  modport master (
    input  start, test_value,
    output core_reset, busy, done, pass, fail, timeout,
           cycle_count, change_count, final_value
  );

  modport slave (
    output start, test_value,
    input  core_reset, busy, done, pass, fail, timeout,
           cycle_count, change_count, final_value
  );
endinterface

// File: rtl/riscv_run_controller.sv
// Run/checkpoint controller: holds the RV32I core in reset, bounds its run time
// and classifies the result from test_value as pass, fail or timeout.
//
//   state | meaning
//   IDLE  | after reset, core held in reset, waiting for a start condition
//   HOLD  | core held in reset for HOLD_CYCLES cycles
//   RUN   | core running, watching test_value for a verdict
//   DONE  | verdict latched, core left running, waiting for start
module riscv_run_controller #(
  parameter int                    TEST_WIDTH    = 16,
  parameter int                    CNT_WIDTH     = 16,
  parameter int                    HOLD_CYCLES   = 10,
  parameter int                    RUN_CYCLES    = 1100,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [TEST_WIDTH-1:0] PASS_VALUE    = TEST_WIDTH'(16'h600D),
  parameter logic [TEST_WIDTH-1:0] FAIL_VALUE    = TEST_WIDTH'(16'hBAD0),
  parameter int                    AUTO_START    = 1
) (
  input logic                    CLK,
  input logic                    RESET,
  riscv_run_controller_if.master bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [HW-1:0]        HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_LAST  = CNT_WIDTH'(RUN_CYCLES - 1);
  localparam logic [SW-1:0]        STABLE_TC = SW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [HW-1:0]         hold_cnt_q;
  logic [SW-1:0]         stable_q;
  logic [TEST_WIDTH-1:0] tv_q;
  logic                  core_reset_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic                  fail_q;
  logic                  timeout_q;
  logic [CNT_WIDTH-1:0]  cycle_count_q;
  logic [CNT_WIDTH-1:0]  change_count_q;
  logic [TEST_WIDTH-1:0] final_value_q;

  logic [SW-1:0] stable_d;
  logic          changed;

  // Streak length including the current cycle; the first RUN cycle has no valid
  // predecessor (tv_q still holds a HOLD-phase value), so it never counts as a change.
  always_comb begin
    stable_d = '0;
    if (bus.test_value == PASS_VALUE) stable_d = stable_q + 1'b1;
    changed = (state_q == S_RUN) && (cycle_count_q != '0) && (bus.test_value != tv_q);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q        <= S_IDLE;
      hold_cnt_q     <= '0;
      stable_q       <= '0;
      tv_q           <= '0;
      core_reset_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      cycle_count_q  <= '0;
      change_count_q <= '0;
      final_value_q  <= '0;
    end else begin
      tv_q <= bus.test_value;
      case (state_q)
        S_IDLE: begin
          if (bus.start || (AUTO_START != 0)) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= HOLD_LOAD;
            busy_q     <= 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == '0) begin
            state_q       <= S_RUN;
            core_reset_q  <= 1'b1;
            cycle_count_q <= '0;
            stable_q      <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (changed && (change_count_q != '1)) change_count_q <= change_count_q + 1'b1;
          stable_q <= stable_d;
          if (bus.test_value == FAIL_VALUE) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            fail_q        <= 1'b1;
            final_value_q <= bus.test_value;
          end else if (stable_d == STABLE_TC) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            pass_q        <= 1'b1;
            final_value_q <= bus.test_value;
          end else if (cycle_count_q == RUN_LAST) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            timeout_q     <= 1'b1;
            final_value_q <= bus.test_value;
          end else begin
            cycle_count_q <= cycle_count_q + 1'b1;
          end
        end
        S_DONE: begin
          // Only an explicit start restarts; the core keeps running until then.
          if (bus.start) begin
            state_q        <= S_HOLD;
            hold_cnt_q     <= HOLD_LOAD;
            stable_q       <= '0;
            core_reset_q   <= 1'b0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
            cycle_count_q  <= '0;
            change_count_q <= '0;
            final_value_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.core_reset   = core_reset_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.timeout      = timeout_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.change_count = change_count_q;
  assign bus.final_value  = final_value_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Scoreboard bench for riscv_run_controller: each run's expected verdict is
// computed from its test_value sequence and checked when done rises.
module tb_riscv_run_controller;
  localparam int TW   = 16;
  localparam int CW   = 16;
  localparam int HOLD = 3;
  localparam int RUN  = 20;
  localparam int STAB = 2;
  localparam logic [15:0] PASSV = 16'h600D;
  localparam logic [15:0] FAILV = 16'hBAD0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_run_controller_if #(.TEST_WIDTH(TW), .CNT_WIDTH(CW)) bus ();

  riscv_run_controller #(
    .TEST_WIDTH(TW), .CNT_WIDTH(CW), .HOLD_CYCLES(HOLD), .RUN_CYCLES(RUN),
    .STABLE_CYCLES(STAB), .PASS_VALUE(PASSV), .FAIL_VALUE(FAILV), .AUTO_START(1)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic [15:0] cc;
    logic [15:0] chg;
    logic [15:0] fv;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] seq [RUN];
  exp_t        sb [$];
  logic        done_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Verdict straight from the rules: walk the per-cycle values in order.
  function automatic exp_t model();
    exp_t e;
    int   streak;
    e = '{p: 1'b0, f: 1'b0, t: 1'b0, cc: 16'h0, chg: 16'h0, fv: 16'h0};
    streak = 0;
    for (int c = 0; c < RUN; c++) begin
      if (c > 0 && seq[c] != seq[c-1]) e.chg = e.chg + 16'd1;
      streak = (seq[c] == PASSV) ? streak + 1 : 0;
      if (seq[c] == FAILV) begin
        e.f = 1'b1; e.cc = 16'(c); e.fv = seq[c]; return e;
      end
      if (streak >= STAB) begin
        e.p = 1'b1; e.cc = 16'(c); e.fv = seq[c]; return e;
      end
      if (c == RUN - 1) begin
        e.t = 1'b1; e.cc = 16'(c); e.fv = seq[c]; return e;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done && !done_d) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pass", bus.pass, e.p);
        check("fail", bus.fail, e.f);
        check("timeout", bus.timeout, e.t);
        check("cycle_count", bus.cycle_count, e.cc);
        check("change_count", bus.change_count, e.chg);
        check("final_value", bus.final_value, e.fv);
        check("one_flag", $countones({bus.pass, bus.fail, bus.timeout}), 32'd1);
      end
    end
    done_d = bus.done;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset"}, bus.core_reset, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_flags"}, {bus.pass, bus.fail, bus.timeout}, 0);
    check({tag, "_counts"}, {bus.cycle_count, bus.change_count}, 0);
    check({tag, "_final"}, bus.final_value, 0);
  endtask

  // Waits for HOLD entry, checks hold length, returns at the first RUN negedge.
  task automatic enter_run(input bit restart, output bit ok);
    int n;
    bus.test_value = 16'h0;
    if (restart) bus.start = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < 8 && !ok) begin
      @(negedge clk);
      n++;
      ok = bus.busy && !bus.core_reset;
    end
    if (!ok) begin
      check("hold_entry", 0, 1);
      bus.start = 1'b0;
      return;
    end
    if (restart) begin
      check("restart_done_clr", bus.done, 0);
      check("restart_flags_clr", {bus.pass, bus.fail, bus.timeout}, 0);
      check("restart_counts_clr", {bus.cycle_count, bus.change_count, bus.final_value}, 0);
    end
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      if (bus.core_reset) break;
      n++;
    end
    check("hold_len", n, HOLD);
    check("busy_run", bus.busy, 1);
    bus.start = 1'b0;
  endtask

  task automatic run_one(input bit restart);
    bit ok;
    int c;
    sb.push_back(model());
    enter_run(restart, ok);
    if (!ok) return;
    c = 0;
    while (c < RUN + 5) begin
      bus.test_value = (c < RUN) ? seq[c] : 16'h0;
      @(negedge clk);
      if (bus.done) break;
      c++;
    end
    check("run_end", bus.done, 1);
    check("busy_done", bus.busy, 0);
    bus.test_value = 16'($urandom);
    repeat (2) @(negedge clk);
    check("done_stays", bus.done, 1);
  endtask

  task automatic reset_mid_run();
    bit ok;
    enter_run(1'b1, ok);
    if (!ok) return;
    for (int c = 0; c <= 8; c++) begin
      bus.test_value = 16'h0;
      if (c == 8) rst_n = 1'b0;
      @(negedge clk);
    end
    check_reset_values("midrun_reset");
    rst_n = 1'b1;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int c = 0; c < RUN; c++) seq[c] = v;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.test_value = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    fill(16'h0);
    for (int c = 5; c < RUN; c++) seq[c] = PASSV;
    run_one(1'b0);

    fill(FAILV);
    for (int c = 0; c < 4; c++) seq[c] = 16'h0;
    seq[4] = PASSV;
    seq[5] = 16'h0001;
    run_one(1'b1);

    reset_mid_run();

    fill(16'h0);
    run_one(1'b0);

    fill(16'h0);
    seq[18] = PASSV;
    seq[19] = PASSV;
    run_one(1'b1);

    fill(16'h0);
    seq[19] = FAILV;
    run_one(1'b1);

    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < RUN; c++) begin
        int k;
        k = $urandom_range(0, 19);
        if (k == 0) seq[c] = FAILV;
        else if (k < 6) seq[c] = PASSV;
        else seq[c] = 16'($urandom_range(0, 3));
      end
      run_one(1'b1);
    end

    @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/riscv_run_controller.md
# riscv_run_controller

Synthesizable run/checkpoint controller that sequences the RV32I core's reset, bounds its execution time, and classifies the result from the core's `test_value` output. It replaces the fixed "hold reset 10 cycles, run 1100 cycles, stop" bench sequence with a parametrised FSM. The FSM has pass, fail and timeout detection plus restart capability. It sits between the system clock/reset and `RISCV_TOP`: it drives the core's `RESET` and observes its `test_value`.

## Interface
- `TEST_WIDTH`, 16: width of `test_value`.
- `CNT_WIDTH`, 16: width of the cycle and change counters; must satisfy 2^CNT_WIDTH > RUN_CYCLES.
- `HOLD_CYCLES`, 10: cycles the core is held in reset per run; must be ≥ 1.
- `RUN_CYCLES`, 1100: maximum cycles in RUN before timeout; must be ≥ 1.
- `STABLE_CYCLES`, 4: consecutive cycles `test_value` must equal `PASS_VALUE` to declare pass; must be ≥ 1.
- `PASS_VALUE`, 16'h600D: pass signature.
- `FAIL_VALUE`, 16'hBAD0: fail signature.
- `AUTO_START`, 1: 1 = leave IDLE automatically after reset; 0 = wait for `start`.

Ports:
- `CLK` in 1: single system clock, rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `start` in 1: run request, level-sampled each cycle.
- `test_value` in TEST_WIDTH: core observation value.
- `core_reset` out 1: active-low reset to `RISCV_TOP`.
- `busy` out 1: high in HOLD or RUN.
- `done` out 1: high in DONE.
- `pass` out 1: result flag, sticky until the next run or reset.
- `fail` out 1: result flag, sticky until the next run or reset.
- `timeout` out 1: result flag, sticky until the next run or reset.
- `cycle_count` out CNT_WIDTH: RUN cycles elapsed in the current or last run.
- `change_count` out CNT_WIDTH: number of `test_value` changes seen in RUN; saturates at all-ones.
- `final_value` out TEST_WIDTH: `test_value` sampled on the cycle the run ended.

## Operation
- FSM states: IDLE, HOLD, RUN, DONE. All outputs are registered.
- IDLE:
  - `core_reset` = 0.
  - Goes to HOLD on the next edge if `start`=1 or `AUTO_START`=1.
- HOLD:
  - `core_reset` = 0.
  - A hold counter counts 0..HOLD_CYCLES-1.
  - At the terminal count: go to RUN, set `core_reset` = 1, clear `cycle_count` to 0.
- RUN:
  - `core_reset` = 1. `cycle_count` increments each cycle.
  - Per cycle, evaluated in priority order:
    - `test_value` == FAIL_VALUE → DONE, `fail`=1.
    - Otherwise, the stable counter reaches STABLE_CYCLES (count includes the current cycle) → DONE, `pass`=1.
    - Otherwise, `cycle_count` == RUN_CYCLES-1 → DONE, `timeout`=1.
  - Stable counter: increments while `test_value` == PASS_VALUE; clears on any other value.
  - On exit, `final_value` captures `test_value`.
- Change detection:
  - `test_value` is registered every cycle.
  - A change is a RUN cycle, other than the first RUN cycle, where `test_value` ≠ the registered value. Each change increments `change_count`, saturating.
- DONE:
  - `core_reset` stays 1. The core keeps running; its results are ignored.
  - Counters, flags and `final_value` are frozen.
  - `start`=1 → HOLD. Entering HOLD clears `pass`, `fail`, `timeout`, `cycle_count`, `change_count`, `final_value` and the stable counter.
  - `AUTO_START` does not cause a restart from DONE.
- `start` is ignored in HOLD and RUN.
- Exactly one of `pass`/`fail`/`timeout` is set in DONE; none is set outside DONE.

## Timing
- While `RESET`=0 at an edge:
  - State → IDLE.
  - `core_reset`=0; `busy`, `done`, `pass`, `fail`, `timeout` = 0.
  - `cycle_count`, `change_count`, `final_value`, internal counters = 0.
  - This applies mid-run as well: the core is forced back into reset on the same edge.
- From the first edge with `RESET`=1 and a start condition:
  - IDLE→HOLD takes 1 edge.
  - `core_reset` stays low for exactly HOLD_CYCLES cycles after HOLD entry.
  - `core_reset` rises on the edge that enters RUN.
- RUN length is at most RUN_CYCLES cycles. On timeout, `cycle_count` = RUN_CYCLES-1 in DONE.
- Result latency: `done` and the result flag rise on the edge following the deciding `test_value` sample (1 cycle).
- A fail signature on the same cycle as a completed pass streak → fail wins.
- A pass or fail on the cycle `cycle_count`=RUN_CYCLES-1 → pass/fail wins over timeout.
- `start` held high continuously from DONE → exactly one restart per DONE entry.

## Test plan
Configuration for all scenarios: HOLD_CYCLES=3, RUN_CYCLES=20, STABLE_CYCLES=2, PASS=16'h600D, FAIL=16'hBAD0, AUTO_START=1.
- Reset release → `core_reset` low for 3 cycles after HOLD entry, then high; `busy`=1.
- `test_value`=16'h600D from RUN cycle 5 onward → `done`, `pass`, `cycle_count`=6, `final_value`=16'h600D; `fail`=0, `timeout`=0.
- `test_value`=16'h600D at cycle 4, 16'h0001 at cycle 5, 16'hBAD0 at cycle 6 → `fail`=1 at `cycle_count`=6; `change_count`=3 (0→600D, 600D→1, 1→BAD0).
- `test_value` constant 0 → `timeout`=1, `cycle_count`=19, `change_count`=0.
- In DONE, pulse `start` → flags clear, HOLD re-entered, `core_reset` low 3 cycles. Then assert `RESET`=0 during RUN cycle 8 → all outputs at reset values on the next edge, `core_reset`=0.
- `test_value`=16'h600D on cycles 18–19 → pass wins over timeout at `cycle_count`=19.
